// File: rtl/fm_wm_prod_writer.sv
// fm_wm_prod_writer
// Takes a row-major stream of FM x WM product elements and writes each one
// to the scratch-pad at BASE_ADDRESS + row*WEIGHT_COLS + col. A pass is
// started by a one-cycle start pulse and covers FEATURE_ROWS*WEIGHT_COLS
// elements. The pass ends with a one-cycle done pulse.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse, begins a pass (only honoured in IDLE)
//   product_valid     product_data carries an element
//   product_data      product element
//   product_ready     element accepted when product_valid && product_ready
//   scratch_wr_en     write strobe, one cycle after the accept
//   scratch_wr_addr   write address (held while scratch_wr_en is low)
//   scratch_wr_data   write data    (held while scratch_wr_en is low)
//   row_count         row index of the next element to accept
//   col_count         column index of the next element to accept
//   busy              high in every state except IDLE
//   done              one-cycle end-of-pass pulse
module fm_wm_prod_writer #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int DOT_PROD_WIDTH        = 16,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int BASE_ADDRESS          = 0,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             product_valid,
    input  logic [DOT_PROD_WIDTH-1:0]        product_data,
    output logic                             product_ready,
    output logic                             scratch_wr_en,
    output logic [ADDRESS_WIDTH-1:0]         scratch_wr_addr,
    output logic [DOT_PROD_WIDTH-1:0]        scratch_wr_data,
    output logic [COUNTER_FEATURE_WIDTH-1:0] row_count,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  col_count,
    output logic                             busy,
    output logic                             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

    state_t                             state_q;
    logic                               ready_q;
    logic                               wr_en_q;
    logic [ADDRESS_WIDTH-1:0]           wr_addr_q;
    logic [DOT_PROD_WIDTH-1:0]          wr_data_q;
    logic [COUNTER_FEATURE_WIDTH-1:0]   row_q;
    logic [COUNTER_WEIGHT_WIDTH-1:0]    col_q;
    logic                               busy_q;
    logic                               done_q;

    logic [ADDRESS_WIDTH-1:0]           wr_addr_d;

    // All terms are brought to ADDRESS_WIDTH first so the sum wraps modulo
    // 2^ADDRESS_WIDTH (a base near the top of memory rolls over to 0).
    always_comb begin
        wr_addr_d = ADDRESS_WIDTH'(BASE_ADDRESS)
                  + ADDRESS_WIDTH'(row_q) * ADDRESS_WIDTH'(WEIGHT_COLS)
                  + ADDRESS_WIDTH'(col_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Strobes default low; address/data registers hold between writes.
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WRITE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                WRITE: begin
                    // ready_q is high throughout WRITE, so valid alone is an accept.
                    if (product_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= product_data;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                // Last element: its write shows up during FLUSH.
                                row_q   <= '0;
                                state_q <= FLUSH;
                                ready_q <= 1'b0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign product_ready   = ready_q;
    assign scratch_wr_en   = wr_en_q;
    assign scratch_wr_addr = wr_addr_q;
    assign scratch_wr_data = wr_data_q;
    assign row_count       = row_q;
    assign col_count       = col_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
